// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared types for the imem/dmem memory-port arbiter.
//   - arb_state_type : arbiter FSM state (IDLE / BUSY), backed by plain
//                      localparam codes so legacy code can match on them.
//   - owner_type     : which requester owns a transaction (IMEM / DMEM).
//                      The numeric value doubles as the slot index.
//   - mem_req_type   : one request as presented downstream.
//   - mem_rsp_type   : one response as routed back to a requester.
//   - rr_pick()      : round-robin winner selection.
package mem_arbiter_pkg;

  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_BUSY = 1'b1;

  typedef enum logic [0:0] {
    IDLE = STATE_IDLE,
    BUSY = STATE_BUSY
  } arb_state_type;

  typedef enum logic [0:0] {
    IMEM = 1'b0,
    DMEM = 1'b1
  } owner_type;

  typedef struct packed {
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_type;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ready;
  } mem_rsp_type;

  // With both ports pending, the port that did not finish last wins.
  // A lone pending port wins regardless of history.
  function automatic owner_type rr_pick(input logic imem_pend,
                                        input logic dmem_pend,
                                        input owner_type last_grant);
    if (imem_pend && dmem_pend) begin
      return (last_grant == IMEM) ? DMEM : IMEM;
    end
    return dmem_pend ? DMEM : IMEM;
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_slot.sv
// mem_arbiter_arb_slot
//   Holds the single outstanding request of one requester, from capture
//   until the arbiter frees it on completion.
//   Ports:
//     clock, reset          clock, synchronous active-low reset
//     cap_valid             request pulse from the requester
//     cap_addr/wdata/wstrb  request fields (wstrb forced to 0 when INSTR)
//     free                  owner's transaction completed; release slot
//     pend                  request available for arbitration, including
//                           one being captured this very cycle
//     pend_addr/wdata/wstrb fields of that request
//     viol                  request arrived while the slot was occupied
module mem_arbiter_arb_slot
  import mem_arbiter_pkg::*;
#(
  parameter bit INSTR = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cap_valid,
  input  logic [31:0] cap_addr,
  input  logic [31:0] cap_wdata,
  input  logic [3:0]  cap_wstrb,
  input  logic        free,
  output logic        pend,
  output logic [31:0] pend_addr,
  output logic [31:0] pend_wdata,
  output logic [3:0]  pend_wstrb,
  output logic        viol
);

  mem_req_type slot_reg;
  mem_req_type cap_req;
  logic        accept;

  always_comb begin
    cap_req       = '0;
    cap_req.valid = 1'b1;
    cap_req.instr = INSTR;
    cap_req.addr  = cap_addr;
    cap_req.wdata = cap_wdata;
    cap_req.wstrb = INSTR ? 4'h0 : cap_wstrb;
  end

  // The slot stays occupied while its request is in flight, so a pulse in
  // the completion cycle is still a violation and is dropped.
  assign viol   = cap_valid && slot_reg.valid;
  assign accept = cap_valid && !slot_reg.valid;

  // Bypass lets an idle arbiter issue in the same cycle the pulse arrives.
  assign pend       = slot_reg.valid || accept;
  assign pend_addr  = slot_reg.valid ? slot_reg.addr  : cap_req.addr;
  assign pend_wdata = slot_reg.valid ? slot_reg.wdata : cap_req.wdata;
  assign pend_wstrb = slot_reg.valid ? slot_reg.wstrb : cap_req.wstrb;

  always_ff @(posedge clock) begin
    if (!reset) begin
      slot_reg <= '0;
    end else if (free) begin
      slot_reg.valid <= 1'b0;
    end else if (accept) begin
      slot_reg <= cap_req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one downstream memory port between instruction fetch (imem) and
//   load/store (dmem). One transaction in flight, round-robin on ties,
//   responses routed combinationally to the owner, watchdog on hung
//   transactions, sticky err on any protocol violation or timeout.
//   Parameter TIMEOUT: BUSY cycles without mem_ready before forced
//   completion (0 disables the watchdog).
//   Ports:
//     clock, reset                      clock, synchronous active-low reset
//     imem_valid/addr                   fetch request pulse and address
//     imem_rdata/ready                  fetch response
//     dmem_valid/addr/wdata/wstrb       data request (wstrb 0 = load)
//     dmem_rdata/ready                  data response
//     mem_valid/instr/addr/wdata/wstrb  downstream request
//     mem_rdata/ready                   downstream response
//     err                               sticky error flag
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        err
);

  localparam bit          WDOG_EN   = (TIMEOUT > 0);
  localparam logic [31:0] WDOG_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  // Slot index 0 = IMEM, 1 = DMEM (matches owner_type encoding).
  logic [1:0]  cap_valid;
  logic [31:0] cap_addr   [2];
  logic [31:0] cap_wdata  [2];
  logic [3:0]  cap_wstrb  [2];
  logic [1:0]  slot_free;
  logic [1:0]  slot_pend;
  logic [31:0] slot_addr  [2];
  logic [31:0] slot_wdata [2];
  logic [3:0]  slot_wstrb [2];
  logic [1:0]  slot_viol;

  arb_state_type state_reg;
  owner_type     owner_reg;
  owner_type     last_grant_reg;
  owner_type     pick;
  mem_req_type   mem_req_reg;
  mem_req_type   pick_req;
  mem_rsp_type   rsp;
  logic [31:0]   wdog_cnt_reg;
  logic          err_reg;
  logic          done_ok;
  logic          done_to;
  logic          done;
  logic          spurious;

  assign cap_valid    = {dmem_valid, imem_valid};
  assign cap_addr[0]  = imem_addr;
  assign cap_wdata[0] = 32'h0;
  assign cap_wstrb[0] = 4'h0;
  assign cap_addr[1]  = dmem_addr;
  assign cap_wdata[1] = dmem_wdata;
  assign cap_wstrb[1] = dmem_wstrb;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      mem_arbiter_arb_slot #(
        .INSTR (gi == 0)
      ) u_slot (
        .clock      (clock),
        .reset      (reset),
        .cap_valid  (cap_valid[gi]),
        .cap_addr   (cap_addr[gi]),
        .cap_wdata  (cap_wdata[gi]),
        .cap_wstrb  (cap_wstrb[gi]),
        .free       (slot_free[gi]),
        .pend       (slot_pend[gi]),
        .pend_addr  (slot_addr[gi]),
        .pend_wdata (slot_wdata[gi]),
        .pend_wstrb (slot_wstrb[gi]),
        .viol       (slot_viol[gi])
      );
    end
  endgenerate

  // Winner and its downstream request, only consumed in IDLE.
  always_comb begin
    pick           = rr_pick(slot_pend[0], slot_pend[1], last_grant_reg);
    pick_req       = '0;
    pick_req.valid = 1'b1;
    if (pick == DMEM) begin
      pick_req.instr = 1'b0;
      pick_req.addr  = slot_addr[1];
      pick_req.wdata = slot_wdata[1];
      pick_req.wstrb = slot_wstrb[1];
    end else begin
      pick_req.instr = 1'b1;
      pick_req.addr  = slot_addr[0];
      pick_req.wdata = slot_wdata[0];
      pick_req.wstrb = slot_wstrb[0];
    end
  end

  // Completion is gated by reset so a transaction killed by reset never
  // produces a ready pulse, even with mem_ready in the reset cycle.
  // A real mem_ready beats a watchdog expiry in the same cycle.
  assign done_ok  = reset && (state_reg == BUSY) && mem_ready;
  assign done_to  = reset && WDOG_EN && (state_reg == BUSY) && !mem_ready &&
                    (wdog_cnt_reg == WDOG_LAST);
  assign done     = done_ok || done_to;
  assign spurious = (state_reg == IDLE) && mem_ready;

  assign slot_free[0] = done && (owner_reg == IMEM);
  assign slot_free[1] = done && (owner_reg == DMEM);

  always_comb begin
    rsp.ready = done;
    rsp.rdata = done_ok ? mem_rdata : 32'h0;
  end

  assign imem_ready = rsp.ready && (owner_reg == IMEM);
  assign dmem_ready = rsp.ready && (owner_reg == DMEM);
  assign imem_rdata = (owner_reg == IMEM) ? rsp.rdata : 32'h0;
  assign dmem_rdata = (owner_reg == DMEM) ? rsp.rdata : 32'h0;

  assign mem_valid = mem_req_reg.valid;
  assign mem_instr = mem_req_reg.instr;
  assign mem_addr  = mem_req_reg.addr;
  assign mem_wdata = mem_req_reg.wdata;
  assign mem_wstrb = mem_req_reg.wstrb;
  assign err       = err_reg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg      <= IDLE;
      owner_reg      <= IMEM;
      last_grant_reg <= IMEM;
      mem_req_reg    <= '0;
      wdog_cnt_reg   <= 32'd0;
      err_reg        <= 1'b0;
    end else begin
      // mem_valid is a one-cycle pulse; the other fields hold until the
      // next issue.
      mem_req_reg.valid <= 1'b0;
      if (|slot_viol || spurious || done_to) begin
        err_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (|slot_pend) begin
            state_reg    <= BUSY;
            owner_reg    <= pick;
            mem_req_reg  <= pick_req;
            wdog_cnt_reg <= 32'd0;
          end
        end
        BUSY: begin
          if (done) begin
            state_reg      <= IDLE;
            last_grant_reg <= owner_reg;
            wdog_cnt_reg   <= 32'd0;
          end else begin
            wdog_cnt_reg <= wdog_cnt_reg + 32'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
